clock_divider_multi: RTL and testbench
======================================

Name: clock_divider_multi

Overview:
- N-channel programmable clock-enable/divider generator; successor to the single fixed-ratio divider.
- Per-channel runtime divisor, duty (high-time), enable and one-cycle tick.
- Glitch-free reconfiguration applied only at a period boundary.
- Sits between the system clock and slow peripherals (LED blink, UART baud, sample strobes); all logic runs on clk rising edge only.

Parameters:
- NUM_CH, 4, number of independent channels.
- CH_IDX_W, 2, width of channel select; must be at least clog2(NUM_CH).
- DIV_WIDTH, 24, width of divisor, high-time and counters.
- DEFAULT_DIV, 12000000, divisor loaded into every channel at reset.

Ports:
- clk  in  1  system clock; rising edge only.
- rst  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when valid&ready.
- cfg_ch  in  CH_IDX_W  target channel.
- cfg_div  in  DIV_WIDTH  new period in clk cycles.
- cfg_high  in  DIV_WIDTH  new high-time; 0 = 50%.
- div_out  out  NUM_CH  divided clock, registered.
- tick  out  NUM_CH  1-cycle pulse in last cycle of each period.
- pending  out  NUM_CH  shadow config waiting for boundary.

Behaviour:
- Reset (async, rst=1): per channel
  - D_act = DEFAULT_DIV and H_act = 0, then clamped.
  - cnt = D_eff-1; div_out = 0, tick = 0, pending = 0; shadow registers cleared.
  - Any in-flight config is lost.
- Clamp rules, combinational on active values:
  - D_eff = max(D_act, 2).
  - H_eff = D_eff>>1 if H_act = 0, else min(H_act, D_eff-1).
  - Odd D with 50% duty gives high = floor(D/2).
- Counter, enabled channel: cnt = cnt==D_eff-1 ? 0 : cnt+1.
  - div_out <= (cnt_next < H_eff).
  - tick <= (cnt_next == D_eff-1).
  - Outputs are aligned with cnt. After reset with en=1, D=4: div_out = 1,1,0,0 repeating, tick = 0,0,0,1.
- Disabled channel (en=0): cnt is held or forced to D_eff-1; div_out = 0, tick = 0.
  - On re-enable, the first edge moves cnt to 0 and div_out to 1. Every period starts high.
  - Disable mid-period truncates that period immediately; the next edge forces cnt to D_eff-1.
- Config handshake:
  - cfg_ready = ~pending[cfg_ch], combinational.
  - cfg_ch >= NUM_CH gives cfg_ready = 1, and the write is dropped.
  - On accept: shadow_div/shadow_high[cfg_ch] load and pending[cfg_ch] is set.
  - Apply edge = any edge where the channel's cnt == D_eff-1 and pending = 1.
  - On apply: D_act/H_act take the shadow values and pending clears.
  - If en=1, cnt -> 0 and outputs are computed with the new values.
  - If en=0, cnt -> new D_eff-1.
- Accept on the same edge as a period boundary: new config waits for the next boundary; it is never applied the same edge.
- Latency: disabled channel applies 1 edge after accept; enabled channel applies at the first wrap after accept.
- Channels are fully independent; only one config accepted per cycle.

Optional Feature:
- Macro: CLOCK_DIVIDER_MULTI_SYNC_EN.
- With macro:
  - Adds input sync_req [1] and output sync_busy [1].
  - sync_req=1 for one cycle forces cnt = D_eff-1, div_out = 0 and tick = 0 on all channels at the next edge; applies pending configs unconditionally. This phase-aligns channels; enabled channels restart together on the following edge.
  - sync_busy = 1 for that one cycle.
  - sync_req has priority over a simultaneous wrap/apply.
- Without macro: ports absent, no alignment logic.

Decomposition:
- Shared include clock_divider_pkg.vh holds:
  - Effective-divisor clamp minimum (2).
  - Duty-code value 0 = 50%.
  - Default constants.
- Sub-module clock_divider_ch: one channel (counter, shadow registers, clamp, apply, outputs), instantiated NUM_CH times by generate.
- The top holds the config decode, cfg_ready mux and sync fan-out.

Test Plan:
- Reset, en=4'b0001, ch0 configured first (cfg_div=4, cfg_high=0 on disabled ch then enable) -> div_out[0] = 1100 repeating, tick[0] on the 4th cycle, other channels 0.
- Write ch1 div=5, high=0 while enabled at cnt=1 -> pending[1]=1 until the wrap; new period 5 with high 2 starts exactly at cnt=0; no runt pulse.
- Second write to ch1 while pending[1]=1 -> cfg_ready=0; write held off; accepted the cycle after apply.
- cfg_div=0/1 -> behaves as D=2 (10 pattern); cfg_high=9 with div=4 -> high 3 (1110).
- Assert rst mid-period with pending set -> outputs 0 immediately, pending 0, DEFAULT_DIV restored.
- SYNC_EN build: ch0 D=4, ch1 D=8 at arbitrary phases, pulse sync_req -> both div_out rise on the same edge 2 cycles later.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// rtl/clock_divider_pkg.sv - shared constants for the multi-channel clock divider
// Clamp floor, 50%-duty code and default build parameters.
package clock_divider_pkg;

  localparam int CDM_MIN_DIV           = 2;
  localparam int CDM_DUTY_HALF         = 0;
  localparam int CDM_DEFAULT_NUM_CH    = 4;
  localparam int CDM_DEFAULT_CH_IDX_W  = 2;
  localparam int CDM_DEFAULT_DIV_WIDTH = 24;
  localparam int CDM_DEFAULT_DIV       = 12000000;

endpackage

// File: rtl/clock_divider_ch.sv
// rtl/clock_divider_ch.sv - one divider channel: counter, shadow config, clamp, boundary apply
// Optional sync input present only with CLOCK_DIVIDER_MULTI_SYNC_EN.
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH   = CDM_DEFAULT_DIV_WIDTH,
  parameter int DEFAULT_DIV = CDM_DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
  input  logic                 sync,
`endif
  input  logic                 cfg_we,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_high,
  output logic                 div_out,
  output logic                 tick,
  output logic                 pending
);

  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] RST_DEFF = (DEFAULT_DIV < CDM_MIN_DIV) ?
                                              DIV_WIDTH'(CDM_MIN_DIV) : DIV_WIDTH'(DEFAULT_DIV);

  function automatic logic [DIV_WIDTH-1:0] f_d_eff(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(CDM_MIN_DIV)) ? DIV_WIDTH'(CDM_MIN_DIV) : d;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] f_h_eff(input logic [DIV_WIDTH-1:0] d_eff,
                                                   input logic [DIV_WIDTH-1:0] h);
    if (h == DIV_WIDTH'(CDM_DUTY_HALF)) return d_eff >> 1;
    return (h > d_eff - ONE) ? d_eff - ONE : h;
  endfunction

  logic [DIV_WIDTH-1:0] r_d_act, r_h_act, r_sh_div, r_sh_high, r_cnt;
  logic                 r_div_out, r_tick, r_pending;

  logic [DIV_WIDTH-1:0] w_d_eff, w_h_eff, w_d_use, w_h_use, w_cnt_nxt;
  logic                 w_at_end, w_apply, w_sync, w_div_nxt, w_tick_nxt;

`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_d_eff  = f_d_eff(r_d_act);
  assign w_h_eff  = f_h_eff(w_d_eff, r_h_act);
  assign w_at_end = (r_cnt >= w_d_eff - ONE);
  // New values only ever take effect on a period boundary (or a forced sync).
  assign w_apply  = r_pending & (w_at_end | w_sync);
  assign w_d_use  = w_apply ? f_d_eff(r_sh_div) : w_d_eff;
  assign w_h_use  = w_apply ? f_h_eff(w_d_use, r_sh_high) : w_h_eff;

  always_comb begin
    w_cnt_nxt  = w_d_use - ONE;
    w_div_nxt  = 1'b0;
    w_tick_nxt = 1'b0;
    if (en && !w_sync) begin
      w_cnt_nxt  = w_at_end ? '0 : r_cnt + ONE;
      w_div_nxt  = (w_cnt_nxt < w_h_use);
      w_tick_nxt = (w_cnt_nxt == w_d_use - ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_act   <= DIV_WIDTH'(DEFAULT_DIV);
      r_h_act   <= '0;
      r_sh_div  <= '0;
      r_sh_high <= '0;
      r_cnt     <= RST_DEFF - ONE;
      r_div_out <= 1'b0;
      r_tick    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div_out <= w_div_nxt;
      r_tick    <= w_tick_nxt;
      if (w_apply) begin
        r_d_act <= r_sh_div;
        r_h_act <= r_sh_high;
      end
      if (cfg_we) begin
        r_sh_div  <= cfg_div;
        r_sh_high <= cfg_high;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign div_out = r_div_out;
  assign tick    = r_tick;
  assign pending = r_pending;

endmodule

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - N-channel programmable clock-enable/divider with boundary-safe reconfig
// Define CLOCK_DIVIDER_MULTI_SYNC_EN to add the sync_req/sync_busy phase-alignment port pair.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH      = CDM_DEFAULT_NUM_CH,
  parameter int CH_IDX_W    = CDM_DEFAULT_CH_IDX_W,
  parameter int DIV_WIDTH   = CDM_DEFAULT_DIV_WIDTH,
  parameter int DEFAULT_DIV = CDM_DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_IDX_W-1:0]  cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_high,
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
  input  logic                 sync_req,
  output logic                 sync_busy,
`endif
  output logic [NUM_CH-1:0]    div_out,
  output logic [NUM_CH-1:0]    tick,
  output logic [NUM_CH-1:0]    pending
);

  logic [31:0]       w_ch_ext;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_we;

  assign w_ch_ext = 32'(cfg_ch);
  // An out-of-range channel selects nothing, so it reads as ready and the write is dropped.
  assign cfg_ready = ~|(w_sel & pending);

`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
  assign sync_busy = sync_req;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_sel[g] = (w_ch_ext == 32'(g));
    assign w_we[g]  = cfg_valid & w_sel[g] & ~pending[g];

    clock_divider_ch #(
      .DIV_WIDTH  (DIV_WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
      .sync    (sync_req),
`endif
      .cfg_we  (w_we[g]),
      .cfg_div (cfg_div),
      .cfg_high(cfg_high),
      .div_out (div_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - directed self-checking bench for clock_divider_multi
module tb_clock_divider_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_div;
  logic [23:0] cfg_high;
  logic [3:0]  div_out;
  logic [3:0]  tick;
  logic [3:0]  pending;
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
  logic        sync_req;
  logic        sync_busy;
`endif

  int errors = 0;
  int checks = 0;

  clock_divider_multi #(
    .NUM_CH(4), .CH_IDX_W(2), .DIV_WIDTH(24), .DEFAULT_DIV(12000000)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high),
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
    .sync_req(sync_req), .sync_busy(sync_busy),
`endif
    .div_out(div_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [23:0] d, input logic [23:0] h);
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_high  = h;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 4'b0000; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = '0; cfg_high = '0;
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
    sync_req = 1'b0;
`endif
    step(2);
    checks++; if (div_out !== 4'b0000) begin errors++; $display("FAIL reset_div_out: got %b expected 0000", div_out); end
    checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL reset_tick: got %b expected 0000", tick); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    rst = 1'b0;
    step(1);
    en = 4'b1000;
    // Default divisor is huge: channel 3 must stay high with no tick for many cycles.
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({div_out, tick} !== 8'b1000_0000) begin
        errors++; $display("FAIL default_div cyc%0d: got div=%b tick=%b expected div=1000 tick=0000", i, div_out, tick);
      end
    end
    en = 4'b0000;
    step(1);
    checks++; if (div_out !== 4'b0000) begin errors++; $display("FAIL disable_truncate: got %b expected 0000", div_out); end
  endtask

  task automatic test_basic_ch0;
    cfg_ch = 2'd0; cfg_div = 24'd4; cfg_high = 24'd0; cfg_valid = 1'b1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ch0_ready: got %b expected 1", cfg_ready); end
    step(1);
    cfg_valid = 1'b0;
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL ch0_pending_set: got %b expected 0001", pending); end
    step(1);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ch0_pending_clr: got %b expected 0000", pending); end
    en = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] exp;
      step(1);
      exp = {3'b000, ((i % 4) < 2) ? 1'b1 : 1'b0, 3'b000, ((i % 4) == 3) ? 1'b1 : 1'b0};
      checks++;
      if ({div_out, tick} !== exp) begin
        errors++; $display("FAIL ch0_d4 cyc%0d: got %b expected %b", i, {div_out, tick}, exp);
      end
    end
  endtask

  task automatic test_reconfig_ch1;
    logic [1:0] exp_a [0:2];
    logic [1:0] exp_b [0:4];
    exp_a = '{2'b10, 2'b00, 2'b01};
    exp_b = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    cfg_write(2'd1, 24'd3, 24'd0);
    step(1);
    en = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if ({div_out[1], tick[1]} !== exp_a[i]) begin
        errors++; $display("FAIL ch1_d3 cyc%0d: got %b expected %b", i, {div_out[1], tick[1]}, exp_a[i]);
      end
    end
    cfg_ch = 2'd1; cfg_div = 24'd5; cfg_high = 24'd0; cfg_valid = 1'b1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ch1_ready: got %b expected 1", cfg_ready); end
    step(1);
    cfg_valid = 1'b0;
    checks++;
    if ({div_out[1], tick[1], pending[1]} !== {exp_a[2], 1'b1}) begin
      errors++; $display("FAIL ch1_old_period_end: got %b expected %b", {div_out[1], tick[1], pending[1]}, {exp_a[2], 1'b1});
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++;
      if ({div_out[1], tick[1]} !== exp_b[i]) begin
        errors++; $display("FAIL ch1_d5 cyc%0d: got %b expected %b", i, {div_out[1], tick[1]}, exp_b[i]);
      end
      if (i == 0) begin
        checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL ch1_pending_clr: got %b expected 0", pending[1]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    step(1);
    cfg_ch = 2'd1; cfg_div = 24'd6; cfg_high = 24'd0; cfg_valid = 1'b1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_first: got %b expected 1", cfg_ready); end
    step(1);
    cfg_div = 24'd2; cfg_high = 24'd1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_held_off: got %b expected 0", cfg_ready); end
    step(3);
    checks++;
    if ({cfg_ready, pending[1]} !== 2'b01) begin
      errors++; $display("FAIL b2b_still_held: got ready/pend=%b expected 01", {cfg_ready, pending[1]});
    end
    step(1);
    checks++;
    if ({cfg_ready, pending[1], div_out[1]} !== 3'b101) begin
      errors++; $display("FAIL b2b_applied: got ready/pend/div=%b expected 101", {cfg_ready, pending[1], div_out[1]});
    end
    step(1);
    cfg_valid = 1'b0;
    checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %b expected 1", pending[1]); end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp;
      step(1);
      exp = {(i == 0) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0};
      checks++;
      if ({div_out[1], tick[1]} !== exp) begin
        errors++; $display("FAIL b2b_d6 cyc%0d: got %b expected %b", i, {div_out[1], tick[1]}, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp;
      step(1);
      exp = ((i % 2) == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({div_out[1], tick[1]} !== exp) begin
        errors++; $display("FAIL b2b_d2 cyc%0d: got %b expected %b", i, {div_out[1], tick[1]}, exp);
      end
    end
  endtask

  task automatic test_clamp;
    logic [23:0] divs  [0:2];
    logic [23:0] highs [0:2];
    divs  = '{24'd0, 24'd1, 24'd4};
    highs = '{24'd0, 24'd0, 24'd9};
    for (int k = 0; k < 3; k++) begin
      en[2] = 1'b0;
      step(1);
      checks++;
      if ({div_out[2], tick[2]} !== 2'b00) begin
        errors++; $display("FAIL clamp_disabled k%0d: got %b expected 00", k, {div_out[2], tick[2]});
      end
      cfg_write(2'd2, divs[k], highs[k]);
      step(1);
      en[2] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        logic [1:0] exp;
        step(1);
        if (k < 2) exp = ((i % 2) == 0) ? 2'b10 : 2'b01;
        else       exp = {((i % 4) < 3) ? 1'b1 : 1'b0, ((i % 4) == 3) ? 1'b1 : 1'b0};
        checks++;
        if ({div_out[2], tick[2]} !== exp) begin
          errors++; $display("FAIL clamp k%0d cyc%0d: got %b expected %b", k, i, {div_out[2], tick[2]}, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    cfg_write(2'd0, 24'd9, 24'd0);
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL rstmid_pending_before: got %b expected 1", pending[0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({div_out, tick, pending} !== 12'h000) begin
      errors++; $display("FAIL rstmid_async: got div=%b tick=%b pend=%b expected all 0", div_out, tick, pending);
    end
    step(1);
    rst = 1'b0;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", cfg_ready); end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checks++;
      if ({div_out, tick} !== 8'b0111_0000) begin
        errors++; $display("FAIL rstmid_default cyc%0d: got div=%b tick=%b expected div=0111 tick=0000", i, div_out, tick);
      end
    end
  endtask

`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
  task automatic test_sync;
    en = 4'b0000;
    step(1);
    cfg_write(2'd0, 24'd4, 24'd0);
    cfg_write(2'd1, 24'd8, 24'd0);
    step(1);
    en = 4'b0001;
    step(1);
    en = 4'b0011;
    step(2);
    sync_req = 1'b1;
    checks++; if (sync_busy !== 1'b1) begin errors++; $display("FAIL sync_busy_high: got %b expected 1", sync_busy); end
    step(1);
    sync_req = 1'b0;
    checks++;
    if ({div_out[1:0], tick[1:0], sync_busy} !== 5'b00000) begin
      errors++; $display("FAIL sync_forced: got %b expected 00000", {div_out[1:0], tick[1:0], sync_busy});
    end
    step(1);
    checks++; if (div_out[1:0] !== 2'b11) begin errors++; $display("FAIL sync_rise: got %b expected 11", div_out[1:0]); end
    step(1);
    checks++; if (div_out[1:0] !== 2'b11) begin errors++; $display("FAIL sync_cnt1: got %b expected 11", div_out[1:0]); end
    step(1);
    checks++; if (div_out[1:0] !== 2'b10) begin errors++; $display("FAIL sync_cnt2: got %b expected 10", div_out[1:0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_ch0();
    test_reconfig_ch1();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
`ifdef CLOCK_DIVIDER_MULTI_SYNC_EN
    test_sync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
